// File: rtl/lru_square_matrix_pkg.sv
// Shared definitions for the square-matrix LRU tracker.
//   SET_BITS : default set index width
//   WAYS     : associativity (this version supports 4 only)
//   way_t    : way index
//   matrix_t : one set's matrix, m[row][col]; bit = 1 means "row used more
//              recently than col"
//   row_or   : per-row OR, bit r = 0 marks way r as an LRU candidate
package lru_square_matrix_pkg;
  localparam int SET_BITS = 3;
  localparam int WAYS     = 4;

  typedef logic [1:0]                     way_t;
  typedef logic [WAYS-1:0][WAYS-1:0]      matrix_t;

  function automatic logic [WAYS-1:0] row_or(input matrix_t m);
    logic [WAYS-1:0] v;
    v = '0;
    for (int r = 0; r < WAYS; r++) v[r] = |m[r];
    return v;
  endfunction
endpackage

// File: rtl/lru_square_matrix_next.sv
// Combinational next-state of one set's LRU matrix.
//   m_i                  : current matrix
//   inv_en_i / inv_way_i : invalidate (way becomes least recent)
//   acc_en_i / acc_way_i : access (way becomes most recent)
//   m_o                  : next matrix
// Invalidate is applied before access, so an access to the same way wins.
module lru_matrix_next
  import lru_square_matrix_pkg::*;
(
  input  matrix_t m_i,
  input  logic    inv_en_i,
  input  way_t    inv_way_i,
  input  logic    acc_en_i,
  input  way_t    acc_way_i,
  output matrix_t m_o
);

  always_comb begin
    m_o = m_i;
    if (inv_en_i) begin
      for (int r = 0; r < WAYS; r++) begin
        if (way_t'(r) == inv_way_i) m_o[r] = '0;
        else                        m_o[r][inv_way_i] = 1'b1;
      end
    end
    if (acc_en_i) begin
      for (int r = 0; r < WAYS; r++) begin
        if (way_t'(r) == acc_way_i) m_o[r] = ~(4'b0001 << acc_way_i);
        else                        m_o[r][acc_way_i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lru_square_matrix.sv
// Per-set 4-way LRU tracker (square-matrix method).
//   clk, reset          : clock, async active-high reset
//   access_*            : mark a way most-recently-used
//   inval_*             : mark a way least-recently-used
//   query_valid/_set    : request the row-OR vector of a set
//   squareMatrixOut     : registered row-OR vector (0 bit = LRU candidate)
//   out_valid           : query_valid delayed one cycle
// Three next-state instances: the access path (which also folds in a
// same-set invalidate), the invalidate path, and the query bypass so a
// query sees same-cycle updates.
module lru_square_matrix
  import lru_square_matrix_pkg::*;
#(
  parameter int SET_BITS = lru_square_matrix_pkg::SET_BITS,
  parameter int WAYS     = lru_square_matrix_pkg::WAYS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                access_valid,
  input  logic [SET_BITS-1:0] access_set,
  input  logic [1:0]          access_way,
  input  logic                inval_valid,
  input  logic [SET_BITS-1:0] inval_set,
  input  logic [1:0]          inval_way,
  input  logic                query_valid,
  input  logic [SET_BITS-1:0] query_set,
  output logic [3:0]          squareMatrixOut,
  output logic                out_valid
);

  localparam int NSETS = 1 << SET_BITS;

  if (WAYS != 4) begin : g_ways_chk
    $error("lru_square_matrix: WAYS must be 4");
  end

  matrix_t [NSETS-1:0] mat_q, mat_d;
  logic    [3:0]       sq_q, sq_d;
  logic                vld_q;

  matrix_t acc_nxt, inv_nxt, qry_nxt;
  logic    same_ai, qry_acc, qry_inv;

  assign same_ai = inval_valid  && (inval_set  == access_set);
  assign qry_acc = access_valid && (access_set == query_set);
  assign qry_inv = inval_valid  && (inval_set  == query_set);

  lru_matrix_next u_acc (
    .m_i(mat_q[access_set]), .inv_en_i(same_ai), .inv_way_i(inval_way),
    .acc_en_i(access_valid), .acc_way_i(access_way), .m_o(acc_nxt)
  );

  lru_matrix_next u_inv (
    .m_i(mat_q[inval_set]), .inv_en_i(inval_valid), .inv_way_i(inval_way),
    .acc_en_i(1'b0), .acc_way_i(access_way), .m_o(inv_nxt)
  );

  lru_matrix_next u_qry (
    .m_i(mat_q[query_set]), .inv_en_i(qry_inv), .inv_way_i(inval_way),
    .acc_en_i(qry_acc), .acc_way_i(access_way), .m_o(qry_nxt)
  );

  always_comb begin
    mat_d = mat_q;
    // A same-set invalidate is already folded into acc_nxt.
    if (inval_valid && !(access_valid && same_ai)) mat_d[inval_set] = inv_nxt;
    if (access_valid)                              mat_d[access_set] = acc_nxt;
    sq_d = query_valid ? row_or(qry_nxt) : sq_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mat_q <= '0;
      sq_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      mat_q <= mat_d;
      sq_q  <= sq_d;
      vld_q <= query_valid;
    end
  end

  assign squareMatrixOut = sq_q;
  assign out_valid       = vld_q;

endmodule

// File: tb/tb_lru_square_matrix.sv
module tb_lru_square_matrix;
  localparam int SB = 3;
  localparam int NS = 1 << SB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          access_valid = 1'b0, inval_valid = 1'b0, query_valid = 1'b0;
  logic [SB-1:0] access_set = '0, inval_set = '0, query_set = '0;
  logic [1:0]    access_way = '0, inval_way = '0;
  logic [3:0]    squareMatrixOut;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  lru_square_matrix #(.SET_BITS(SB), .WAYS(4)) dut (
    .clk(clk), .reset(reset),
    .access_valid(access_valid), .access_set(access_set), .access_way(access_way),
    .inval_valid(inval_valid), .inval_set(inval_set), .inval_way(inval_way),
    .query_valid(query_valid), .query_set(query_set),
    .squareMatrixOut(squareMatrixOut), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: per way, the time and kind of its last event.
  // For a pair (r,c) the later of their last events decides the order:
  // r ranks above c if that event was an access of r or an invalidate of c.
  // A way is an LRU candidate (bit 0) if it ranks above no other way.
  int  last_t  [NS][4];
  bit  last_acc[NS][4];
  int  tcnt;
  logic [3:0] exp_out;
  logic       exp_valid;

  function automatic bit above(int s, int r, int c);
    if (r == c) return 1'b0;
    if (last_t[s][r] < 0 && last_t[s][c] < 0) return 1'b0;
    if (last_t[s][r] > last_t[s][c]) return last_acc[s][r];
    return !last_acc[s][c];
  endfunction

  function automatic logic [3:0] lru_vec(int s);
    logic [3:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (above(s, r, c)) v[r] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 4; w++) begin
          last_t[s][w]   = -1;
          last_acc[s][w] = 1'b0;
        end
      tcnt = 0;
      exp_out   <= '0;
      exp_valid <= 1'b0;
    end else begin
      tcnt++;
      // invalidate ordered before access within one cycle
      if (inval_valid) begin
        last_t[inval_set][inval_way]   = 2 * tcnt;
        last_acc[inval_set][inval_way] = 1'b0;
      end
      if (access_valid) begin
        last_t[access_set][access_way]   = 2 * tcnt + 1;
        last_acc[access_set][access_way] = 1'b1;
      end
      exp_valid <= query_valid;
      if (query_valid) exp_out <= lru_vec(int'(query_set));
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    checks++;
    if (out_valid !== exp_valid || squareMatrixOut !== exp_out) begin
      errors++;
      $display("FAIL model_cmp t=%0t got v=%b o=%b exp v=%b o=%b",
               $time, out_valid, squareMatrixOut, exp_valid, exp_out);
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, changed 2 time units after the rising edge.
  task automatic drive(input bit av, input int as, input int aw,
                       input bit iv, input int is, input int iw,
                       input bit qv, input int qs);
    @(posedge clk);
    #2;
    access_valid = av; access_set = SB'(as); access_way = 2'(aw);
    inval_valid  = iv; inval_set  = SB'(is); inval_way  = 2'(iw);
    query_valid  = qv; query_set  = SB'(qs);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Call right after the drive() that follows a query cycle.
  task automatic expect_q(input string name, input logic [3:0] exp);
    #1;
    chk({name, "_valid"}, {3'b000, out_valid}, 4'b0001);
    chk(name, squareMatrixOut, exp);
  endtask

  task automatic async_reset();
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_out", squareMatrixOut, 4'b0000);
    chk("rst_async_vld", {3'b000, out_valid}, 4'b0000);
    access_valid = 0; inval_valid = 0; query_valid = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_out", squareMatrixOut, 4'b0000);
    chk("rst_vld", {3'b000, out_valid}, 4'b0000);
    reset = 1'b0;

    // 1: untouched set
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    idle(); expect_q("q_set5_reset", 4'b0000);

    // 2: fill all ways of set 2
    for (int w = 0; w < 4; w++) drive(1, 2, w, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    idle(); expect_q("q_fill", 4'b1110);

    // 3: re-access way 0, then invalidate way 3
    drive(1, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    idle(); expect_q("q_acc0", 4'b1101);
    drive(0, 0, 0, 1, 2, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    idle(); expect_q("q_inv3", 4'b0111);

    // 4: access + query same set, same cycle (bypass). Way 3 stays the
    // invalidated LRU, so bit 3 remains 0.
    drive(1, 2, 1, 0, 0, 0, 1, 2);
    idle(); expect_q("q_bypass", 4'b0111);

    // 5: same set/way access+invalidate: access wins
    drive(1, 2, 2, 1, 2, 2, 1, 2);
    idle(); expect_q("q_acc_wins", 4'b0111);
    // different sets in one cycle
    drive(1, 1, 3, 1, 4, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 4); expect_q("q_set1", 4'b1000);
    idle(); expect_q("q_set4", 4'b1110);

    // 6: async reset between edges
    drive(1, 2, 0, 0, 0, 0, 1, 2);
    async_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    idle(); expect_q("q_after_rst", 4'b0000);

    // Randomized phase, with set collisions favoured
    for (int i = 0; i < 3000; i++) begin
      int base;
      base = $urandom_range(0, NS - 1);
      drive($urandom_range(0, 1), base, $urandom_range(0, 3),
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 1) == 1) ? base : $urandom_range(0, NS - 1),
            $urandom_range(0, 3),
            $urandom_range(0, 1),
            ($urandom_range(0, 1) == 1) ? base : $urandom_range(0, NS - 1));
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
